// File: rtl/sdram_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_test_pkg
// Purpose  : Shared state encoding and LFSR helpers for the SDRAM test master.
// Revision : 1.0
// ============================================================================
package sdram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so substitute a known-good one.
    function automatic logic [15:0] eff_seed(input logic [15:0] s);
        return (s == 16'h0000) ? DEFAULT_SEED : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_test_master_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Fibonacci LFSR with synchronous load and step enable.
// Revision : 1.0
// ============================================================================
module lfsr16
    import sdram_test_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] q_o
);

    logic [15:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= seed_i;
        end else if (step_i) begin
            q_q <= lfsr_step(q_q);
        end
    end

    assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/sdram_test_master.sv
`default_nettype none
// ============================================================================
// Module   : sdram_test_master
// Purpose  : Avalon-MM SDRAM pattern tester: LFSR fill, pipelined readback, check.
// Revision : 1.0
// ============================================================================
module sdram_test_master
    import sdram_test_pkg::*;
#(
    parameter int unsigned       ADDR_W          = 24,
    parameter int unsigned       DATA_W          = 16,
    parameter logic [ADDR_W-1:0] START_ADDR      = '0,
    parameter logic [ADDR_W-1:0] END_ADDR        = '1,
    parameter logic [15:0]       SEED            = 16'h0001,
    parameter int unsigned       MAX_OUTSTANDING = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic [1:0]        avm_byteenable_n,
    output logic              avm_chipselect,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read_n,
    output logic              avm_write_n,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_e            state_q;
    logic              cs_q;
    logic              read_n_q;
    logic              write_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] chk_addr_q;
    logic [3:0]        out_q;
    logic [3:0]        out_d;
    logic [15:0]       err_q;
    logic [ADDR_W-1:0] ferr_addr_q;
    logic              ferr_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic [15:0] gen_q;
    logic [15:0] chk_q;

    logic w_start;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_rvalid;
    logic w_last;
    logic w_mismatch;

    assign w_start    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_wr_acc   = cs_q && !write_n_q && !avm_waitrequest;
    assign w_rd_acc   = cs_q && !read_n_q && !avm_waitrequest;
    // A response with nothing outstanding is stray unless it pairs with this cycle's accept.
    assign w_rvalid   = avm_readdatavalid && ((out_q != 4'd0) || w_rd_acc);
    assign w_last     = (addr_q == END_ADDR);
    assign w_mismatch = w_rvalid && (avm_readdata != chk_q);

    always_comb begin
        out_d = out_q;
        if (w_rd_acc && !w_rvalid) begin
            out_d = out_q + 4'd1;
        end else if (!w_rd_acc && w_rvalid) begin
            out_d = out_q - 4'd1;
        end
    end

    lfsr16 u_gen (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .load_i (w_start),
        .seed_i (eff_seed(SEED)),
        .step_i (w_wr_acc),
        .q_o    (gen_q)
    );

    lfsr16 u_chk (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .load_i (w_wr_acc && w_last),
        .seed_i (eff_seed(SEED)),
        .step_i (w_rvalid),
        .q_o    (chk_q)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            cs_q         <= 1'b0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            addr_q       <= '0;
            chk_addr_q   <= '0;
            out_q        <= '0;
            err_q        <= '0;
            ferr_addr_q  <= '0;
            ferr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            out_q <= out_d;
            if (w_rvalid) begin
                chk_addr_q <= chk_addr_q + 1'b1;
                if (w_mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_q <= err_q + 16'd1;
                    end
                    if (!ferr_valid_q) begin
                        ferr_addr_q  <= chk_addr_q;
                        ferr_valid_q <= 1'b1;
                    end
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        state_q      <= ST_WRITE;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        ferr_addr_q  <= '0;
                        ferr_valid_q <= 1'b0;
                        cs_q         <= 1'b1;
                        write_n_q    <= 1'b0;
                        addr_q       <= START_ADDR;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_acc) begin
                        if (w_last) begin
                            // Go straight into reading; nothing is outstanding yet.
                            state_q    <= ST_READ;
                            write_n_q  <= 1'b1;
                            read_n_q   <= 1'b0;
                            addr_q     <= START_ADDR;
                            chk_addr_q <= START_ADDR;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_rd_acc && w_last) begin
                        state_q  <= ST_DRAIN;
                        read_n_q <= 1'b1;
                        cs_q     <= 1'b0;
                    end else begin
                        if (w_rd_acc) begin
                            addr_q <= addr_q + 1'b1;
                        end
                        // A stalled command stays presented: out_d cannot grow without an accept.
                        read_n_q <= !(out_d < MAX_OUT);
                        cs_q     <= (out_d < MAX_OUT);
                    end
                end
                ST_DRAIN: begin
                    if (out_q == 4'd0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == 16'd0);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avm_address      = addr_q;
    assign avm_byteenable_n = 2'b00;
    assign avm_chipselect   = cs_q;
    assign avm_writedata    = gen_q;
    assign avm_read_n       = read_n_q;
    assign avm_write_n      = write_n_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_q;
    assign first_err_addr   = ferr_addr_q;
    assign first_err_valid  = ferr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_test_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sdram_test_master
// Purpose  : Scoreboard bench for sdram_test_master with a latency/stall memory model.
// Revision : 1.0
// ============================================================================
module tb_sdram_test_master;

    localparam int MAXO [3] = '{8, 2, 2};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st     [3] = '{default: 1'b0};
    logic [23:0] addr   [3];
    logic [1:0]  be     [3];
    logic        cs     [3];
    logic [15:0] wd     [3];
    logic        rn     [3];
    logic        wn     [3];
    logic [15:0] rdata  [3] = '{default: 16'h0};
    logic        rvalid [3] = '{default: 1'b0};
    logic        waitr  [3] = '{default: 1'b0};
    logic        busy   [3];
    logic        done   [3];
    logic        pass   [3];
    logic [15:0] ecnt   [3];
    logic [23:0] fea    [3];
    logic        fev    [3];

    sdram_test_master #(.ADDR_W(24), .DATA_W(16), .START_ADDR(24'h000000), .END_ADDR(24'h000007),
                        .SEED(16'h0001), .MAX_OUTSTANDING(8)) u_dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(st[0]), .avm_address(addr[0]),
        .avm_byteenable_n(be[0]), .avm_chipselect(cs[0]), .avm_writedata(wd[0]),
        .avm_read_n(rn[0]), .avm_write_n(wn[0]), .avm_readdata(rdata[0]),
        .avm_readdatavalid(rvalid[0]), .avm_waitrequest(waitr[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_cnt(ecnt[0]), .first_err_addr(fea[0]),
        .first_err_valid(fev[0]));

    sdram_test_master #(.ADDR_W(24), .DATA_W(16), .START_ADDR(24'h000000), .END_ADDR(24'h000007),
                        .SEED(16'h1234), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(st[1]), .avm_address(addr[1]),
        .avm_byteenable_n(be[1]), .avm_chipselect(cs[1]), .avm_writedata(wd[1]),
        .avm_read_n(rn[1]), .avm_write_n(wn[1]), .avm_readdata(rdata[1]),
        .avm_readdatavalid(rvalid[1]), .avm_waitrequest(waitr[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_cnt(ecnt[1]), .first_err_addr(fea[1]),
        .first_err_valid(fev[1]));

    sdram_test_master #(.ADDR_W(24), .DATA_W(16), .START_ADDR(24'h000010), .END_ADDR(24'h000010),
                        .SEED(16'h0000), .MAX_OUTSTANDING(2)) u_dut_c (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(st[2]), .avm_address(addr[2]),
        .avm_byteenable_n(be[2]), .avm_chipselect(cs[2]), .avm_writedata(wd[2]),
        .avm_read_n(rn[2]), .avm_write_n(wn[2]), .avm_readdata(rdata[2]),
        .avm_readdatavalid(rvalid[2]), .avm_waitrequest(waitr[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_cnt(ecnt[2]), .first_err_addr(fea[2]),
        .first_err_valid(fev[2]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // Memory model state and per-instance configuration
    logic [15:0] mem  [3][32];
    logic [15:0] fd   [3][16];
    int          fdue [3][16];
    int          fw [3] = '{default: 0};
    int          fr [3] = '{default: 0};
    bit          wait_rand [3] = '{default: 1'b0};
    int          lat_lo [3] = '{1, 10, 1};
    int          lat_hi [3] = '{1, 10, 3};
    bit          corrupt = 1'b0;
    int          cyc = 0;
    int          tbout    [3] = '{default: 0};
    int          maxout   [3] = '{default: 0};
    int          limviol  [3] = '{default: 0};
    int          stabviol [3] = '{default: 0};
    int          nwr      [3] = '{default: 0};
    int          nrd      [3] = '{default: 0};
    bit          pend  [3] = '{default: 1'b0};
    logic [23:0] paddr [3];
    logic        prn [3];
    logic        pwn [3];
    logic [15:0] pwd [3];
    bit          aw, ar;
    logic [15:0] mdat;

    // Scoreboard for instance A: expected write (addr,data) and read addresses
    logic [23:0] wq_a [$];
    logic [15:0] wq_d [$];
    logic [23:0] rq_a [$];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                fw[k] = 0; fr[k] = 0; tbout[k] = 0; pend[k] = 1'b0;
                rvalid[k] <= 1'b0;
                waitr[k]  <= 1'b0;
            end else begin
                aw = cs[k] && !wn[k] && !waitr[k];
                ar = cs[k] && !rn[k] && !waitr[k];
                if (pend[k] && !(cs[k] && addr[k] == paddr[k] && rn[k] == prn[k] && wn[k] == pwn[k]
                                 && (wn[k] || wd[k] == pwd[k])))
                    stabviol[k]++;
                pend[k]  = cs[k] && (!rn[k] || !wn[k]) && waitr[k];
                paddr[k] = addr[k]; prn[k] = rn[k]; pwn[k] = wn[k]; pwd[k] = wd[k];

                if (ar && tbout[k] >= MAXO[k]) limviol[k]++;
                tbout[k] = tbout[k] + (ar ? 1 : 0) - (rvalid[k] ? 1 : 0);
                if (tbout[k] > maxout[k]) maxout[k] = tbout[k];

                if (fw[k] != fr[k] && fdue[k][fr[k] % 16] <= cyc) begin
                    rvalid[k] <= 1'b1;
                    rdata[k]  <= fd[k][fr[k] % 16];
                    fr[k]++;
                end else begin
                    rvalid[k] <= 1'b0;
                    rdata[k]  <= 16'($urandom);
                end

                if (aw) begin
                    mem[k][addr[k][4:0]] = wd[k];
                    nwr[k]++;
                    if (k == 0) begin
                        chk("wr_expected", 32'(wq_a.size() != 0), 32'd1);
                        if (wq_a.size() != 0) begin
                            chk("wr_addr", 32'(addr[0]), 32'(wq_a.pop_front()));
                            chk("wr_data", 32'(wd[0]), 32'(wq_d.pop_front()));
                        end
                    end
                end
                if (ar) begin
                    mdat = mem[k][addr[k][4:0]];
                    if (k == 0 && corrupt && (addr[0] == 24'd5 || addr[0] == 24'd6)) mdat = 16'h0000;
                    fd[k][fw[k] % 16]   = mdat;
                    fdue[k][fw[k] % 16] = cyc + int'($urandom_range(lat_hi[k], lat_lo[k]));
                    fw[k]++;
                    nrd[k]++;
                    if (k == 0) begin
                        chk("rd_expected", 32'(rq_a.size() != 0), 32'd1);
                        if (rq_a.size() != 0) chk("rd_addr", 32'(addr[0]), 32'(rq_a.pop_front()));
                    end
                end
                waitr[k] <= wait_rand[k] ? 1'($urandom_range(1, 0)) : 1'b0;
            end
        end
    end

    task automatic load_exp();
        logic [15:0] v;
        v = 16'h0001;
        wq_a.delete(); wq_d.delete(); rq_a.delete();
        for (int i = 0; i < 8; i++) begin
            wq_a.push_back(24'(i));
            wq_d.push_back(v);
            rq_a.push_back(24'(i));
            mem[0][i] = 16'hDEAD;
            v = nxt(v);
        end
    endtask

    task automatic pulse(input int k);
        @(negedge clk) st[k] = 1'b1;
        @(negedge clk) st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while (done[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done[k]), 32'd1);
    endtask

    initial begin
        logic [15:0] v;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_read_n",  32'(rn[0]),   32'd1);
        chk("rst_write_n", 32'(wn[0]),   32'd1);
        chk("rst_cs",      32'(cs[0]),   32'd0);
        chk("rst_addr",    32'(addr[0]), 32'd0);
        chk("rst_wdata",   32'(wd[0]),   32'd0);
        chk("rst_be",      32'(be[0]),   32'd0);
        chk("rst_busy",    32'(busy[0]), 32'd0);
        chk("rst_done",    32'(done[0]), 32'd0);
        chk("rst_pass",    32'(pass[0]), 32'd0);
        chk("rst_errcnt",  32'(ecnt[0]), 32'd0);
        chk("rst_feaddr",  32'(fea[0]),  32'd0);
        chk("rst_fevalid", 32'(fev[0]),  32'd0);
        rst_n = 1'b1;

        // Ideal memory: no stalls, latency 1
        load_exp();
        pulse(0);
        wait_done(0, "t1_done");
        chk("t1_pass",   32'(pass[0]), 32'd1);
        chk("t1_errcnt", 32'(ecnt[0]), 32'd0);
        chk("t1_busy",   32'(busy[0]), 32'd0);
        chk("t1_wq",     32'(wq_a.size()), 32'd0);
        chk("t1_rq",     32'(rq_a.size()), 32'd0);
        chk("t1_mem7",   32'(mem[0][7]), 32'h0080);
        v = 16'h0001;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_mem%0d", i), 32'(mem[0][i]), 32'(v));
            v = nxt(v);
        end

        // Random stalls and latency 1-6, plus a start pulse during WRITE
        wait_rand[0] = 1'b1; lat_lo[0] = 1; lat_hi[0] = 6;
        load_exp();
        pulse(0);
        chk("t2_wr_phase", 32'(wn[0]), 32'd0);
        pulse(0);
        wait_done(0, "t2_done");
        chk("t2_pass",    32'(pass[0]), 32'd1);
        chk("t2_wq",      32'(wq_a.size()), 32'd0);
        chk("t2_rq",      32'(rq_a.size()), 32'd0);
        chk("t2_stable",  32'(stabviol[0]), 32'd0);
        chk("t2_limit",   32'(limviol[0]), 32'd0);
        chk("t2_maxout8", 32'(maxout[0] <= 8), 32'd1);

        // Corrupted reads at addresses 5 and 6
        corrupt = 1'b1;
        load_exp();
        pulse(0);
        wait_done(0, "t3_done");
        chk("t3_errcnt",  32'(ecnt[0]), 32'd2);
        chk("t3_feaddr",  32'(fea[0]),  32'd5);
        chk("t3_fevalid", 32'(fev[0]),  32'd1);
        chk("t3_pass",    32'(pass[0]), 32'd0);

        // Rerun from DONE clears the prior failure
        corrupt = 1'b0;
        load_exp();
        pulse(0);
        chk("t4_errclr",  32'(ecnt[0]), 32'd0);
        chk("t4_fevclr",  32'(fev[0]),  32'd0);
        chk("t4_doneclr", 32'(done[0]), 32'd0);
        chk("t4_busy",    32'(busy[0]), 32'd1);
        wait_done(0, "t4_done");
        chk("t4_pass",    32'(pass[0]), 32'd1);

        // Asynchronous reset during READ
        wait_rand[0] = 1'b0; lat_lo[0] = 6; lat_hi[0] = 6;
        load_exp();
        pulse(0);
        n = 0;
        while (rn[0] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_read", 32'(rn[0]), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_read_n", 32'(rn[0]),   32'd1);
        chk("t5_write_n", 32'(wn[0]),  32'd1);
        chk("t5_cs",     32'(cs[0]),   32'd0);
        chk("t5_addr",   32'(addr[0]), 32'd0);
        chk("t5_wdata",  32'(wd[0]),   32'd0);
        chk("t5_busy",   32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_exp();
        pulse(0);
        wait_done(0, "t5_done");
        chk("t5_pass",   32'(pass[0]), 32'd1);
        chk("t5_errcnt", 32'(ecnt[0]), 32'd0);

        // Instance B: two reads in flight against latency 10
        pulse(1);
        wait_done(1, "t6_done");
        chk("t6_pass",   32'(pass[1]), 32'd1);
        chk("t6_limit",  32'(limviol[1]), 32'd0);
        chk("t6_maxout", 32'(maxout[1]), 32'd2);
        chk("t6_nwr",    32'(nwr[1]), 32'd8);
        chk("t6_nrd",    32'(nrd[1]), 32'd8);

        // Instance C: single-word range with substituted seed
        wait_rand[2] = 1'b1;
        pulse(2);
        wait_done(2, "t7_done");
        chk("t7_pass",   32'(pass[2]), 32'd1);
        chk("t7_nwr",    32'(nwr[2]), 32'd1);
        chk("t7_nrd",    32'(nrd[2]), 32'd1);
        chk("t7_mem",    32'(mem[2][16]), 32'hACE1);
        chk("t7_stable", 32'(stabviol[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_test_master.md
Name: sdram_test_master

Overview:
Avalon-MM master that sits directly upstream of the SDRAM controller's Avalon slave port (24-bit word address, 16-bit data, active-low read/write/byteenable). On `start` it fills an address range with an LFSR pattern, reads the range back with pipelined reads, and checks each returned word in order. It reports busy, done, pass, an error count and the first failing address to board-level status logic (LEDs, debug).

Parameters:
- ADDR_W, 24, Avalon word-address width.
- DATA_W, 16, data width. Fixed at 16 because the LFSR is 16 bits.
- START_ADDR, 24'h000000, first word address tested.
- END_ADDR, 24'hFFFFFF, last word address tested, inclusive. Must be >= START_ADDR.
- SEED, 16'h0001, LFSR seed. A value of 0 is replaced by 16'hACE1.
- MAX_OUTSTANDING, 8, maximum read commands in flight (1..15).

Ports:
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a test. Honoured in IDLE or DONE only.
- avm_address  out  ADDR_W  word address.
- avm_byteenable_n  out  2  constant 2'b00 (all bytes enabled).
- avm_chipselect  out  1  high while a read or write command is presented.
- avm_writedata  out  DATA_W  write data.
- avm_read_n  out  1  active-low read command.
- avm_write_n  out  1  active-low write command.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_cnt == 0.
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_valid  out  1  set on the first mismatch.

Behaviour:
- Reset values (async): state IDLE; avm_read_n=1, avm_write_n=1, avm_chipselect=0, avm_address=0, avm_writedata=0; busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, first_err_valid=0; outstanding=0. Reset asserted mid-test aborts immediately; no command completion is attempted.
- All Avalon outputs are registered.
- Command acceptance: a command is accepted in a cycle where it is presented (chipselect=1 and read_n or write_n low) and avm_waitrequest=0. While waitrequest=1, address, writedata, read_n and write_n hold stable.
- IDLE:
  - start -> WRITE.
  - Clear err_cnt, first_err_* and pass.
  - Load gen_lfsr=SEED, wr_addr=START_ADDR.
- WRITE:
  - Present write_n=0, address=wr_addr, writedata=gen_lfsr.
  - On each accept: wr_addr+1, gen_lfsr steps.
  - Accept with wr_addr==END_ADDR -> READ. Write strobes deassert in the next cycle, with no gap beyond that.
  - On entry to READ: rd_addr=START_ADDR, chk_lfsr=SEED, chk_addr=START_ADDR.
- READ:
  - Present read_n=0 only while outstanding < MAX_OUTSTANDING. Otherwise read_n=1 and chipselect=0.
  - On each accept: rd_addr+1.
  - Accept with rd_addr==END_ADDR -> DRAIN.
- outstanding counter:
  - +1 on read accept, -1 on readdatavalid; simultaneous events leave it unchanged.
  - readdatavalid while outstanding==0 (and no accept in that cycle) is ignored: no count change, no check.
- Check, on every counted readdatavalid:
  - Compare avm_readdata with chk_lfsr, then step chk_lfsr and increment chk_addr.
  - On mismatch: err_cnt+1, saturating.
  - If first_err_valid==0: capture first_err_addr=chk_addr and set first_err_valid.
- DRAIN: outstanding==0 -> DONE. Responses may arrive in the same cycle as the last read accept.
- DONE:
  - done=1, pass=(err_cnt==0). Outputs hold until the next start.
  - start -> WRITE, with the same initialisation as from IDLE.
- start is ignored while busy.
- LFSR: 16-bit Fibonacci, next = {q[14:0], q[15]^q[13]^q[12]^q[10]}. From 0x0001 the sequence is 0001, 0002, 0004, … 0400, 0801, …
- Single-word range (START_ADDR==END_ADDR): one write, one read, then DONE.
- Response ordering: in-order responses are required; there is no reorder support.

Decomposition:
- Package sdram_test_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - LFSR tap constant;
  - default non-zero seed 16'hACE1;
  - a step function.
- Sub-module lfsr16 (load, seed, step enable, q), instantiated twice: once for the generator, once for the checker.

Test Plan:
- START_ADDR=0, END_ADDR=7, SEED=1, ideal memory model with zero waitrequest -> writes 0001, 0002, 0004 … 0080 to addresses 0-7. Then 8 reads, done=1, pass=1, err_cnt=0.
- Same setup with random waitrequest (50%) and read latency 1-6 cycles -> identical write sequence. Command fields stay stable while stalled. outstanding never exceeds 8. pass=1.
- Model corrupts the read of address 5 (returns 0x0000) and address 6 -> err_cnt=2, first_err_addr=5, first_err_valid=1, pass=0.
- MAX_OUTSTANDING=2 with model latency 10 -> at most 2 reads between readdatavalids. No read is issued when outstanding==2. Test completes with pass=1.
- reset_reset_n pulsed low mid-READ -> all outputs return to reset values immediately. A later start reruns the test cleanly with pass=1.
- start pulsed during WRITE is ignored. start in DONE reruns the test and clears err_cnt from a prior failing run. START_ADDR=END_ADDR=24'h000010 gives exactly 1 write and 1 read.
